// File: rtl/qpsk_mod.sv
// Coherent QPSK modulator: pairs serial bits into dibits and emits one carrier period of I*cos + Q*sin per symbol.
// Optional differential (quadrant-accumulating) mapping is selected by defining QPSK_DIFF_EN.
module qpsk_mod #(
    parameter int unsigned SPS = 20,
    parameter int unsigned AMP = 63
) (
    input  logic              clk_20,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic signed [7:0] qpsk_out,
    output logic signed [7:0] sin_ref,
    output logic signed [7:0] cos_ref,
    output logic              out_valid,
    output logic              sym_start,
    output logic              underrun
);

    localparam int unsigned KW   = $clog2(SPS);
    localparam int unsigned SW   = 8;
    localparam int unsigned FRAC = 28;

    // Angles in Q28 radians.
    localparam longint TWO_PI_Q  = 64'sd1686629713;
    localparam longint PI_Q      = 64'sd843314857;
    localparam longint HALF_PI_Q = 64'sd421657428;
    localparam longint HALF_LSB  = 64'sd134217728;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Elaboration-time round(AMP*sin) / round(AMP*cos) using an integer Taylor series.
    function automatic logic signed [SW-1:0] rom_val(input int unsigned k, input logic is_cos);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint r;
        x = (TWO_PI_Q * longint'(k)) / longint'(SPS);
        if (is_cos) x = x + HALF_PI_Q;
        if (x > PI_Q) x = x - TWO_PI_Q;
        if (x > HALF_PI_Q) x = PI_Q - x;
        else if (x < -HALF_PI_Q) x = -PI_Q - x;
        x2   = (x * x) >>> FRAC;
        term = x;
        acc  = x;
        for (int n = 1; n <= 6; n++) begin
            term = -(((term * x2) >>> FRAC) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        r = acc * longint'(AMP);
        if (r >= 0) r = (r + HALF_LSB) >>> FRAC;
        else        r = -((-r + HALF_LSB) >>> FRAC);
        return SW'(r);
    endfunction

    logic signed [SW-1:0] w_sin_t [SPS];
    logic signed [SW-1:0] w_cos_t [SPS];

    for (genvar g = 0; g < SPS; g++) begin : g_rom
        localparam logic signed [SW-1:0] SIN_V = rom_val(g, 1'b0);
        localparam logic signed [SW-1:0] COS_V = rom_val(g, 1'b1);
        assign w_sin_t[g] = SIN_V;
        assign w_cos_t[g] = COS_V;
    end

    state_t               r_state;
    logic [KW-1:0]        r_k;
    logic                 r_half;
    logic                 r_have_half;
    logic                 r_pend_b0;
    logic                 r_pend_b1;
    logic                 r_pend_valid;
    logic                 r_cur_i;
    logic                 r_cur_q;
    logic signed [SW-1:0] r_qpsk;
    logic signed [SW-1:0] r_sin;
    logic signed [SW-1:0] r_cos;
    logic                 r_out_valid;
    logic                 r_sym_start;
    logic                 r_underrun;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_load;
    logic                 w_emit;
    logic                 w_under;
    logic                 w_emit_i;
    logic                 w_emit_q;
    logic [KW-1:0]        w_emit_k;
    logic                 w_load_i;
    logic                 w_load_q;
    logic signed [SW-1:0] w_sin_s;
    logic signed [SW-1:0] w_cos_s;
    logic signed [SW:0]   w_cos_term;
    logic signed [SW:0]   w_sin_term;

    assign bit_ready = !r_pend_valid;
    assign w_accept  = bit_valid && !r_pend_valid;
    assign w_last    = (r_k == KW'(SPS - 1));

`ifdef QPSK_DIFF_EN
    logic [1:0] r_quad;
    logic [1:0] w_step;
    logic [1:0] w_quad_next;

    // Dibit {first, second} advances the transmitted quadrant.
    always_comb begin
        w_step = 2'd0;
        unique case ({r_pend_b0, r_pend_b1})
            2'b00: w_step = 2'd0;
            2'b01: w_step = 2'd1;
            2'b11: w_step = 2'd2;
            2'b10: w_step = 2'd3;
        endcase
        w_quad_next = r_quad + w_step;
        w_load_i    = (w_quad_next == 2'd0) || (w_quad_next == 2'd3);
        w_load_q    = (w_quad_next == 2'd0) || (w_quad_next == 2'd1);
    end
`else
    assign w_load_i = r_pend_b1;
    assign w_load_q = r_pend_b0;
`endif

    // Choose the sample to register next: a fresh symbol, the next index, or nothing.
    always_comb begin
        w_load   = 1'b0;
        w_emit   = 1'b0;
        w_under  = 1'b0;
        w_emit_k = '0;
        w_emit_i = r_cur_i;
        w_emit_q = r_cur_q;
        if (r_state == S_IDLE || w_last) begin
            if (r_pend_valid) begin
                w_load   = 1'b1;
                w_emit   = 1'b1;
                w_emit_i = w_load_i;
                w_emit_q = w_load_q;
            end else if (r_state == S_RUN) begin
                w_under = 1'b1;
            end
        end else begin
            w_emit   = 1'b1;
            w_emit_k = r_k + KW'(1);
        end
    end

    assign w_sin_s    = w_sin_t[w_emit_k];
    assign w_cos_s    = w_cos_t[w_emit_k];
    assign w_cos_term = w_emit_i ? (SW+1)'(w_cos_s) : -((SW+1)'(w_cos_s));
    assign w_sin_term = w_emit_q ? (SW+1)'(w_sin_s) : -((SW+1)'(w_sin_s));

    always_ff @(posedge clk_20) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_half       <= 1'b0;
            r_have_half  <= 1'b0;
            r_pend_b0    <= 1'b0;
            r_pend_b1    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_cur_i      <= 1'b0;
            r_cur_q      <= 1'b0;
            r_qpsk       <= '0;
            r_sin        <= '0;
            r_cos        <= '0;
            r_out_valid  <= 1'b0;
            r_sym_start  <= 1'b0;
            r_underrun   <= 1'b0;
`ifdef QPSK_DIFF_EN
            r_quad       <= 2'd0;
`endif
        end else begin
            // Accepts never coincide with a load: ready is low while pending is full.
            if (w_accept) begin
                if (r_have_half) begin
                    r_pend_b0    <= r_half;
                    r_pend_b1    <= bit_in;
                    r_pend_valid <= 1'b1;
                    r_have_half  <= 1'b0;
                end else begin
                    r_half      <= bit_in;
                    r_have_half <= 1'b1;
                end
            end
            if (w_load) begin
                r_pend_valid <= 1'b0;
                r_cur_i      <= w_load_i;
                r_cur_q      <= w_load_q;
`ifdef QPSK_DIFF_EN
                r_quad       <= w_quad_next;
`endif
            end

            unique case (r_state)
                S_IDLE: begin
                    r_k <= '0;
                    if (w_load) r_state <= S_RUN;
                end
                S_RUN: begin
                    r_k <= w_emit_k;
                    if (w_under) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_k     <= '0;
                end
            endcase

            r_out_valid <= w_emit;
            r_sym_start <= w_emit && (w_emit_k == '0);
            r_underrun  <= w_under;
            r_qpsk      <= w_emit ? SW'(w_cos_term + w_sin_term) : '0;
            r_sin       <= w_emit ? w_sin_s : '0;
            r_cos       <= w_emit ? w_cos_s : '0;
        end
    end

    assign qpsk_out  = r_qpsk;
    assign sin_ref   = r_sin;
    assign cos_ref   = r_cos;
    assign out_valid = r_out_valid;
    assign sym_start = r_sym_start;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_qpsk_mod.sv
// Bench for qpsk_mod: directed scenarios plus randomized handshake traffic, checked every cycle
// against a sample-level reference model and a correlator loopback.
module tb_qpsk_mod;

    localparam int SPS  = 20;
    localparam int AMP  = 63;
    localparam int NRND = 240;

`ifdef QPSK_DIFF_EN
    localparam int S11_K0 = -63;
    localparam int S11_K5 = -63;
    localparam int S11_K10 = 63;
    localparam int RST_K0 = -63;
`else
    localparam int S11_K0 = 63;
    localparam int S11_K5 = 63;
    localparam int S11_K10 = -63;
    localparam int RST_K0 = 63;
`endif

    logic              clk_20 = 1'b0;
    logic              rst = 1'b1;
    logic              bit_in = 1'b0;
    logic              bit_valid = 1'b0;
    logic              bit_ready;
    logic signed [7:0] qpsk_out;
    logic signed [7:0] sin_ref;
    logic signed [7:0] cos_ref;
    logic              out_valid;
    logic              sym_start;
    logic              underrun;

    qpsk_mod #(.SPS(SPS), .AMP(AMP)) u_dut (
        .clk_20    (clk_20),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .qpsk_out  (qpsk_out),
        .sin_ref   (sin_ref),
        .cos_ref   (cos_ref),
        .out_valid (out_valid),
        .sym_start (sym_start),
        .underrun  (underrun)
    );

    always #5 clk_20 = ~clk_20;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_stall = 0;

    always @(posedge clk_20) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int ref_tab(input int k, input bit is_cos);
        real a;
        real v;
        a = 2.0 * 3.14159265358979 * k / SPS;
        v = AMP * (is_cos ? $cos(a) : $sin(a));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Reference model: accepted bits become timestamped dibits; samples follow from k and arm signs.
    typedef struct {
        int t;
        bit i;
        bit q;
    } dibit_t;

    dibit_t pend_q[$];
    int     prev_k = -1;
    bit     prev_rst = 1'b1;
    bit     cur_i, cur_q;
    bit     m_have_half = 1'b0;
    bit     m_half;
    int     m_quad = 0;
    int     n_sym = 0;
    int     n_under = 0;
    int     k0_log[$];
    bit     rx_bits[$];
    longint corr_s = 0;
    longint corr_c = 0;
    int     rx_quad = 0;

    always @(negedge clk_20) begin : mon
        int     k;
        bit     start;
        bit     exp_u;
        int     es, ec, eq;
        bit     ri, rq;
        int     st, qd;
        dibit_t d;
        if (prev_rst) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_sym_start", sym_start, 0);
            check_eq("rst_underrun", underrun, 0);
            check_eq("rst_qpsk", qpsk_out, 0);
            check_eq("rst_refs", {24'd0, sin_ref} | {24'd0, cos_ref}, 0);
            check_eq("rst_ready", bit_ready, 1);
            pend_q.delete();
            prev_k = -1;
            m_have_half = 1'b0;
            m_quad = 0;
            rx_quad = 0;
            corr_s = 0;
            corr_c = 0;
        end else begin
            start = (prev_k == -1 || prev_k == SPS - 1) && pend_q.size() > 0 && pend_q[0].t <= cyc - 2;
            if (start) begin
                cur_i = pend_q[0].i;
                cur_q = pend_q[0].q;
                void'(pend_q.pop_front());
                k = 0;
                n_sym++;
            end else if (prev_k >= 0 && prev_k < SPS - 1) begin
                k = prev_k + 1;
            end else begin
                k = -1;
            end
            exp_u = (prev_k == SPS - 1) && !start;
            if (underrun) n_under++;
            es = (k >= 0) ? ref_tab(k, 1'b0) : 0;
            ec = (k >= 0) ? ref_tab(k, 1'b1) : 0;
            eq = (cur_i ? ec : -ec) + (cur_q ? es : -es);
            check_eq("out_valid", out_valid, (k >= 0) ? 1 : 0);
            check_eq("sym_start", sym_start, (k == 0) ? 1 : 0);
            check_eq("underrun", underrun, exp_u ? 1 : 0);
            check_eq("qpsk_out", qpsk_out, (k >= 0) ? eq : 0);
            check_eq("sin_ref", sin_ref, es);
            check_eq("cos_ref", cos_ref, ec);
            check_eq("bit_ready", bit_ready, (pend_q.size() > 0 && pend_q[0].t <= cyc - 1) ? 0 : 1);
            if (sym_start) k0_log.push_back(int'(qpsk_out));
            // Loopback correlator driven purely by the DUT outputs.
            if (sym_start) begin
                corr_s = 0;
                corr_c = 0;
            end
            if (out_valid) begin
                corr_s += longint'(qpsk_out) * longint'(sin_ref);
                corr_c += longint'(qpsk_out) * longint'(cos_ref);
            end
            if (k == SPS - 1) begin
                rq = corr_s > 0;
                ri = corr_c > 0;
`ifdef QPSK_DIFF_EN
                qd = (ri && rq) ? 0 : (!ri && rq) ? 1 : (!ri && !rq) ? 2 : 3;
                st = (qd - rx_quad + 4) % 4;
                rx_quad = qd;
                rx_bits.push_back(st >= 2);
                rx_bits.push_back(st == 1 || st == 2);
`else
                rx_bits.push_back(rq);
                rx_bits.push_back(ri);
`endif
            end
            prev_k = k;
        end
        if (!rst && bit_valid && bit_ready) begin
            if (!m_have_half) begin
                m_half = bit_in;
                m_have_half = 1'b1;
            end else begin
                m_have_half = 1'b0;
                d.t = cyc;
`ifdef QPSK_DIFF_EN
                st = (!m_half && !bit_in) ? 0 : (!m_half && bit_in) ? 1 : (m_half && bit_in) ? 2 : 3;
                m_quad = (m_quad + st) % 4;
                d.i = (m_quad == 0 || m_quad == 3);
                d.q = (m_quad <= 1);
`else
                d.q = m_half;
                d.i = bit_in;
`endif
                pend_q.push_back(d);
            end
        end
        prev_rst = rst;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_20);
            #1;
        end
    endtask

    task automatic push_bit(input bit b);
        bit ok;
        int budget;
        bit_in = b;
        bit_valid = 1'b1;
        budget = 0;
        do begin
            ok = bit_ready;
            if (!ok) n_stall++;
            step();
            budget++;
        end while (!ok && budget < 100);
        if (!ok) check_eq("push_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cyc %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int base;
        int base_u;
        int base_rx;
        int exp_k0[3];
        bit bb[8];
        bit tx[$];
        bit b;
        bit acc;
        int budget;

        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        check_eq("ready_after_rst", bit_ready, 1);

        // Single symbol 1,1
        push_bit(1'b1);
        push_bit(1'b1);
        bit_valid = 1'b0;
        check_eq("ready_pending", bit_ready, 0);
        step(1);
        check_eq("s11_start", sym_start, 1);
        check_eq("s11_k0", qpsk_out, S11_K0);
        step(5);
        check_eq("s11_k5", qpsk_out, S11_K5);
        step(5);
        check_eq("s11_k10", qpsk_out, S11_K10);
        step(10);
        check_eq("s11_underrun", underrun, 1);
        check_eq("s11_idle_out", qpsk_out, 0);
        step(1);
        check_eq("s11_underrun_once", underrun, 0);

        // Arm mapping 0,1
        push_bit(1'b0);
        push_bit(1'b1);
        bit_valid = 1'b0;
        step(1);
        check_eq("arm_k0", qpsk_out, 63);
        step(5);
        check_eq("arm_k5", qpsk_out, -63);
        check_eq("arm_sin_k5", sin_ref, 63);
        check_eq("arm_cos_k5", cos_ref, 0);
        step(20);

        // Mid-symbol reset with a half pair outstanding
        push_bit(1'b1);
        push_bit(1'b1);
        step(6);
        push_bit(1'b1);
        bit_valid = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_ready", bit_ready, 1);
        push_bit(1'b0);
        push_bit(1'b1);
        bit_valid = 1'b0;
        step(1);
        check_eq("midrst_start", sym_start, 1);
        check_eq("midrst_k0", qpsk_out, RST_K0);
        step(25);

        // Back-to-back: 8 bits with valid held high
        base = n_sym;
        base_u = n_under;
        n_stall = 0;
        bb = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) push_bit(bb[i]);
        bit_valid = 1'b0;
        step(4 * SPS);
        check_eq("b2b_symbols", n_sym - base, 4);
        check_eq("b2b_underruns", n_under - base_u, 1);
        check_eq("b2b_ready_low", (n_stall > 0) ? 1 : 0, 1);

        // Dibits 00, 01, 11 from a fresh reset
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        base = k0_log.size();
`ifdef QPSK_DIFF_EN
        exp_k0 = '{63, -63, 63};
`else
        exp_k0 = '{-63, 63, 63};
`endif
        bb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) push_bit(bb[i]);
        bit_valid = 1'b0;
        step(4 * SPS);
        check_eq("seq_symbols", k0_log.size() - base, 3);
        for (int i = 0; i < 3; i++) check_eq("seq_k0", k0_log[base + i], exp_k0[i]);

        // Randomized backpressure with occasional starvation gaps
        base_rx = rx_bits.size();
        for (int i = 0; i < NRND; i++) begin
            b = 1'($urandom);
            tx.push_back(b);
            bit_in = b;
            if ($urandom_range(0, 15) == 0) begin
                bit_valid = 1'b0;
                step($urandom_range(20, 45));
            end
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 200) begin
                bit_valid = ($urandom_range(0, 3) != 0);
                acc = bit_valid && bit_ready;
                step();
                budget++;
            end
            if (!acc) check_eq("rnd_timeout", 0, 1);
        end
        bit_valid = 1'b0;
        step(3 * SPS);
        check_eq("rnd_rx_count", rx_bits.size() - base_rx, NRND);
        for (int i = 0; i < NRND; i++) begin
            if (base_rx + i < rx_bits.size()) check_eq("loopback_bit", rx_bits[base_rx + i], tx[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
